// File: rtl/alu_wide_seq.sv
// Multi-word sequencer: runs one NWORDS x WIDTH operation through a shared
// WIDTH-bit ALU, LSW first, chaining carry and merging flags.
module alu_wide_seq #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [2:0]                op_i,
  input  logic [NWORDS*WIDTH-1:0]   opa_i,
  input  logic [NWORDS*WIDTH-1:0]   opb_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [NWORDS*WIDTH-1:0]   result_o,
  output logic                      flag_v_o,
  output logic                      flag_c_o,
  output logic                      flag_n_o,
  output logic                      flag_z_o,
  output logic [2:0]                alu_s_o,
  output logic                      alu_cin_o,
  output logic [WIDTH-1:0]          alu_a_o,
  output logic [WIDTH-1:0]          alu_b_o,
  input  logic [WIDTH-1:0]          alu_g_i,
  input  logic                      alu_v_i,
  input  logic                      alu_c_i,
  input  logic                      alu_n_i,
  input  logic                      alu_z_i
);

  localparam int TW = NWORDS * WIDTH;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NWORDS - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [2:0]      op_q, op_d;
  logic [TW-1:0]   opa_q, opa_d;
  logic [TW-1:0]   opb_q, opb_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic            err_q, err_d;
  logic [TW-1:0]   res_q, res_d;
  logic            fv_q, fv_d;
  logic            fc_q, fc_d;
  logic            fn_q, fn_d;
  logic            fz_q, fz_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      fv_q    <= 1'b0;
      fc_q    <= 1'b0;
      fn_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      err_q   <= err_d;
      res_q   <= res_d;
      fv_q    <= fv_d;
      fc_q    <= fc_d;
      fn_q    <= fn_d;
      fz_q    <= fz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    err_d   = err_q;
    res_d   = res_q;
    fv_d    = fv_q;
    fc_d    = fc_q;
    fn_d    = fn_q;
    fz_d    = fz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d = op_i;
          if (op_i == OP_RSV) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b0;
            opa_d   = opa_i;
            opb_d   = opb_i;
            k_d     = '0;
            carry_d = 1'b0;
            zacc_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        for (int w = 0; w < NWORDS; w++) begin
          if (k_q == KW'(w)) begin
            res_d[w*WIDTH +: WIDTH] = alu_g_i;
          end
        end
        carry_d = alu_c_i;
        zacc_d  = zacc_q & alu_z_i;
        k_d     = k_q + 1'b1;
        // Only the top word's V/N are meaningful for the full-width value.
        if (k_q == KLAST) begin
          fc_d    = alu_c_i;
          fv_d    = alu_v_i;
          fn_d    = alu_n_i;
          fz_d    = zacc_q & alu_z_i;
          k_d     = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic first_w;
  assign first_w = (k_q == '0);

  always_comb begin
    alu_s_o   = 3'b000;
    alu_cin_o = 1'b0;
    alu_a_o   = '0;
    alu_b_o   = '0;
    if (state_q == S_RUN) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (k_q == KW'(w)) begin
          alu_a_o = opa_q[w*WIDTH +: WIDTH];
          alu_b_o = opb_q[w*WIDTH +: WIDTH];
        end
      end
      unique case (op_q)
        OP_ADD: begin
          alu_s_o   = 3'b001;
          alu_cin_o = first_w ? 1'b0 : carry_q;
        end
        OP_SUB: begin
          alu_s_o   = 3'b010;
          alu_cin_o = first_w ? 1'b1 : carry_q;
        end
        OP_AND:  alu_s_o = 3'b100;
        OP_OR:   alu_s_o = 3'b101;
        OP_XOR:  alu_s_o = 3'b110;
        OP_NOT:  alu_s_o = 3'b111;
        OP_PASS: alu_s_o = 3'b000;
        default: alu_s_o = 3'b000;
      endcase
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_FIN);
  assign err_o    = err_q;
  assign result_o = res_q;
  assign flag_v_o = fv_q;
  assign flag_c_o = fc_q;
  assign flag_n_o = fn_q;
  assign flag_z_o = fz_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq with a behavioural 16-bit ALU attached.
module tb_alu_wide_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done, err;
  logic [31:0] result;
  logic        fv, fc, fn, fz;
  logic [2:0]  alu_s;
  logic        alu_cin;
  logic [15:0] alu_a, alu_b, alu_g;
  logic        alu_v, alu_c, alu_n, alu_z;

  int total = 0;
  int bad   = 0;

  alu_wide_seq #(.WIDTH(16), .NWORDS(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
    .opa_i(opa), .opb_i(opb), .busy_o(busy), .done_o(done), .err_o(err),
    .result_o(result), .flag_v_o(fv), .flag_c_o(fc), .flag_n_o(fn),
    .flag_z_o(fz), .alu_s_o(alu_s), .alu_cin_o(alu_cin),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_g_i(alu_g),
    .alu_v_i(alu_v), .alu_c_i(alu_c), .alu_n_i(alu_n), .alu_z_i(alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] sum17;
  always_comb begin
    sum17 = '0;
    alu_g = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_s)
      3'b000: alu_g = alu_a;
      3'b001: begin
        sum17 = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
        alu_g = sum17[15:0];
        alu_c = sum17[16];
        alu_v = (alu_a[15] == alu_b[15]) && (alu_g[15] != alu_a[15]);
      end
      3'b010: begin
        sum17 = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(alu_cin);
        alu_g = sum17[15:0];
        alu_c = sum17[16];
        alu_v = (alu_a[15] != alu_b[15]) && (alu_g[15] != alu_a[15]);
      end
      3'b100: alu_g = alu_a & alu_b;
      3'b101: alu_g = alu_a | alu_b;
      3'b110: alu_g = alu_a ^ alu_b;
      3'b111: alu_g = ~alu_a;
      default: alu_g = '0;
    endcase
    alu_n = alu_g[15];
    alu_z = (alu_g == 16'h0000);
  end

  // Observations from the last do_op call.
  int          lat;
  logic        cin0, cin1, busy_seen;
  logic [2:0]  s0, s1;
  logic [15:0] a0, a1;

  function automatic logic [35:0] ref_logic(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (o)
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      default: r = a;
    endcase
    return {r, 1'b0, 1'b0, r[31], (r == 32'd0)};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    lat = -1; busy_seen = 1'b0;
    cin0 = 1'bx; cin1 = 1'bx; s0 = 3'bx; s1 = 3'bx; a0 = 'x; a1 = 'x;
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; opa = $urandom; opb = $urandom;
    if (done) lat = 0;
    else begin
      busy_seen = busy; s0 = alu_s; cin0 = alu_cin; a0 = alu_a;
      for (int n = 1; n <= 8; n++) begin
        @(posedge clk); #1;
        if (busy) begin
          busy_seen = 1'b1; s1 = alu_s; cin1 = alu_cin; a1 = alu_a;
        end
        if (done) begin
          lat = n;
          break;
        end
      end
    end
    if (lat < 0) $display("FAIL do_op_timeout op=%b", o);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, result, fv, fc, fn, fz, alu_s, alu_cin,
         alu_a, alu_b} !== 75'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b res=%h s=%b",
               busy, done, result, alu_s);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    do_op(3'b000, 32'h0000FFFF, 32'h00000001);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL add_latency got %0d want 2", lat); end
    total++;
    if ({s0, cin0, s1, cin1} !== {3'b001, 1'b0, 3'b001, 1'b1}) begin
      bad++; $display("FAIL add_sel_cin got %b%b %b%b want 0010 0011", s0, cin0, s1, cin1);
    end
    total++;
    if (a0 !== 16'hFFFF || a1 !== 16'h0000) begin
      bad++; $display("FAIL add_alu_a got %h %h want ffff 0000", a0, a1);
    end
    total++;
    if ({result, fc, fv, fn, fz} !== {32'h00010000, 4'b0000}) begin
      bad++; $display("FAIL add_carry_chain got %h cvnz=%b%b%b%b want 00010000 0000",
                      result, fc, fv, fn, fz);
    end
    do_op(3'b000, 32'h7FFFFFFF, 32'h00000001);
    total++;
    if ({result, fc, fv, fn, fz} !== {32'h80000000, 4'b0110}) begin
      bad++; $display("FAIL add_overflow got %h cvnz=%b%b%b%b want 80000000 0110",
                      result, fc, fv, fn, fz);
    end
    do_op(3'b000, 32'hFFFFFFFF, 32'h00000001);
    total++;
    if ({result, fc, fv, fn, fz} !== {32'h00000000, 4'b1001}) begin
      bad++; $display("FAIL add_wrap got %h cvnz=%b%b%b%b want 00000000 1001",
                      result, fc, fv, fn, fz);
    end
  endtask

  task automatic test_sub;
    do_op(3'b001, 32'h00000000, 32'h00000001);
    total++;
    if ({s0, cin0, s1, cin1} !== {3'b010, 1'b1, 3'b010, 1'b0}) begin
      bad++; $display("FAIL sub_sel_cin got %b%b %b%b want 0101 0100", s0, cin0, s1, cin1);
    end
    total++;
    if ({result, fc, fv, fn, fz} !== {32'hFFFFFFFF, 4'b0010}) begin
      bad++; $display("FAIL sub_borrow got %h cvnz=%b%b%b%b want ffffffff 0010",
                      result, fc, fv, fn, fz);
    end
    do_op(3'b001, 32'h00050000, 32'h00050000);
    total++;
    if ({result, fc, fv, fn, fz} !== {32'h00000000, 4'b1001}) begin
      bad++; $display("FAIL sub_equal got %h cvnz=%b%b%b%b want 00000000 1001",
                      result, fc, fv, fn, fz);
    end
  endtask

  task automatic test_logic;
    logic [35:0] exp;
    do_op(3'b100, 32'h12345678, 32'h12345678);
    total++;
    if ({s0, s1, result, fc, fv, fn, fz} !== {3'b110, 3'b110, 32'h0, 4'b0001}) begin
      bad++; $display("FAIL xor_zero got s=%b/%b %h cvnz=%b%b%b%b want 110/110 0 0001",
                      s0, s1, result, fc, fv, fn, fz);
    end
    do_op(3'b101, 32'h0000FFFF, 32'h00000000);
    total++;
    if ({s0, s1, result, fc, fv, fn, fz} !== {3'b111, 3'b111, 32'hFFFF0000, 4'b0010}) begin
      bad++; $display("FAIL not_opa got s=%b/%b %h cvnz=%b%b%b%b want 111/111 ffff0000 0010",
                      s0, s1, result, fc, fv, fn, fz);
    end
    exp = ref_logic(3'b010, 32'hF0F01234, 32'h0FF0FF00);
    do_op(3'b010, 32'hF0F01234, 32'h0FF0FF00);
    total++;
    if ({s0, s1, result, fc, fv, fn, fz} !== {3'b100, 3'b100, exp}) begin
      bad++; $display("FAIL and_model got s=%b/%b %h %b%b%b%b want %h",
                      s0, s1, result, fc, fv, fn, fz, exp);
    end
    exp = ref_logic(3'b011, 32'h80001000, 32'h00200003);
    do_op(3'b011, 32'h80001000, 32'h00200003);
    total++;
    if ({s0, s1, result, fc, fv, fn, fz} !== {3'b101, 3'b101, exp}) begin
      bad++; $display("FAIL or_model got s=%b/%b %h %b%b%b%b want %h",
                      s0, s1, result, fc, fv, fn, fz, exp);
    end
    exp = ref_logic(3'b110, 32'hCAFE0000, 32'h12345678);
    do_op(3'b110, 32'hCAFE0000, 32'h12345678);
    total++;
    if ({s0, s1, result, fc, fv, fn, fz} !== {3'b000, 3'b000, exp}) begin
      bad++; $display("FAIL pass_model got s=%b/%b %h %b%b%b%b want %h",
                      s0, s1, result, fc, fv, fn, fz, exp);
    end
  endtask

  task automatic test_back_to_back;
    int rise[$];
    logic [31:0] dres[$];
    logic prev_busy;
    prev_busy = 1'b0;
    @(negedge clk);
    op = 3'b000; opa = 32'h00000005; opb = 32'h00000003; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) rise.push_back(i);
      if (done) dres.push_back(result);
      if (i == 0) op = 3'b100;
      prev_busy = busy;
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (rise.size() < 3) begin
      bad++; $display("FAIL b2b_accepts got %0d want 3", rise.size());
    end else if (rise[1] - rise[0] != 4 || rise[2] - rise[1] != 4) begin
      bad++; $display("FAIL b2b_period got %0d,%0d,%0d want step 4",
                      rise[0], rise[1], rise[2]);
    end
    total++;
    if (dres.size() < 2) begin
      bad++; $display("FAIL b2b_dones got %0d want >=2", dres.size());
    end else if (dres[0] !== 32'd8 || dres[1] !== 32'd6) begin
      bad++; $display("FAIL b2b_results got %h %h want 8 6", dres[0], dres[1]);
    end
  endtask

  task automatic test_reserved;
    logic [31:0] keep;
    logic [3:0]  kflags;
    do_op(3'b000, 32'h00001234, 32'h00001111);
    keep = result; kflags = {fc, fv, fn, fz};
    @(negedge clk);
    op = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({done, busy, err} !== 3'b101) begin
      bad++; $display("FAIL rsv_done got done=%b busy=%b err=%b want 1 0 1",
                      done, busy, err);
    end
    total++;
    if ({result, fc, fv, fn, fz} !== {keep, kflags}) begin
      bad++; $display("FAIL rsv_hold got %h want %h", result, keep);
    end
    @(posedge clk); #1;
    do_op(3'b000, 32'h00000001, 32'h00000001);
    total++;
    if ({err, result, lat} !== {1'b0, 32'h2, 32'd2}) begin
      bad++; $display("FAIL rsv_clear got err=%b res=%h lat=%0d want 0 2 2",
                      err, result, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    op = 3'b000; opa = 32'h1111FFFF; opb = 32'h22220001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, result, fv, fc, fn, fz, alu_s, alu_cin,
         alu_a, alu_b} !== 75'd0) begin
      bad++; $display("FAIL midrst_outputs got busy=%b res=%h a=%h", busy, result, alu_a);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++; $display("FAIL midrst_no_done got done seen want none");
    end
    do_op(3'b000, 32'h00010001, 32'h00020002);
    total++;
    if ({result, lat} !== {32'h00030003, 32'd2}) begin
      bad++; $display("FAIL midrst_recover got %h lat=%0d want 00030003 2", result, lat);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_back_to_back;
    test_reserved;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
